dispatcher: RTL and testbench

//  Drives the issue side of the arithmetic reserve station and the load/store buffer (LSB): takes one fetched

---
 rtl/dispatcher_pkg.sv | 51 +++++
 rtl/dispatcher_decoder.sv | 142 ++++++++++++++
 rtl/dispatcher.sv | 159 +++++++++++++++
 tb/tb_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the issue-side dispatcher and its decoder.
package dispatcher_pkg;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int OPENUM_W = 6;

  localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;

  // Internal opcode enum; OP_NOP must stay at 0 so a cleared register reads as NOP.
  // Groups are kept contiguous (branches, loads, stores, op-imm, shifts, reg-reg).
  typedef enum logic [OPENUM_W-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } openum_e;

  // Decoded view of one instruction.
  typedef struct packed {
    openum_e           op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] imm;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              is_mem;
  } dec_t;

  // Registered issue record presented to RS / LSB / ROB.
  typedef struct packed {
    logic                en_rs;
    logic                en_lsb;
    logic                en_rob;
    openum_e             op;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc;
    logic [ROB_ID_W-1:0] rob_id;
    logic [4:0]          rd;
  } issue_t;

endpackage

// File: rtl/dispatcher_decoder.sv
// Purely combinational RV32I decoder: raw instruction -> opcode enum, register
// fields, sign-extended immediate, operand usage and memory-class flag.
// Unknown encodings decode to OP_NOP with every other field cleared.
module dispatcher_decoder import dispatcher_pkg::*; (
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  openum_e    op;
  fmt_e       fmt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  // Classify the encoding into an internal opcode and its operand format
  always_comb begin
    op  = OP_NOP;
    fmt = FMT_NONE;
    case (opcode)
      7'b0110111: begin op = OP_LUI;   fmt = FMT_U; end
      7'b0010111: begin op = OP_AUIPC; fmt = FMT_U; end
      7'b1101111: begin op = OP_JAL;   fmt = FMT_J; end
      7'b1100111: if (funct3 == 3'd0) begin op = OP_JALR; fmt = FMT_I; end
      7'b1100011: begin
        fmt = FMT_B;
        case (funct3)
          3'd0: op = OP_BEQ;
          3'd1: op = OP_BNE;
          3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;
          3'd6: op = OP_BLTU;
          3'd7: op = OP_BGEU;
          default: op = OP_NOP;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: op = OP_LB;
          3'd1: op = OP_LH;
          3'd2: op = OP_LW;
          3'd4: op = OP_LBU;
          3'd5: op = OP_LHU;
          default: op = OP_NOP;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (funct3)
          3'd0: op = OP_SB;
          3'd1: op = OP_SH;
          3'd2: op = OP_SW;
          default: op = OP_NOP;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: op = OP_ADDI;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd6: op = OP_ORI;
          3'd7: op = OP_ANDI;
          3'd1: begin fmt = FMT_SH; if (funct7 == 7'h00) op = OP_SLLI; end
          default: begin
            fmt = FMT_SH;
            if (funct7 == 7'h00)      op = OP_SRLI;
            else if (funct7 == 7'h20) op = OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        case ({funct7, funct3})
          {7'h00, 3'd0}: op = OP_ADD;
          {7'h20, 3'd0}: op = OP_SUB;
          {7'h00, 3'd1}: op = OP_SLL;
          {7'h00, 3'd2}: op = OP_SLT;
          {7'h00, 3'd3}: op = OP_SLTU;
          {7'h00, 3'd4}: op = OP_XOR;
          {7'h00, 3'd5}: op = OP_SRL;
          {7'h20, 3'd5}: op = OP_SRA;
          {7'h00, 3'd6}: op = OP_OR;
          {7'h00, 3'd7}: op = OP_AND;
          default:       op = OP_NOP;
        endcase
      end
      default: op = OP_NOP;
    endcase
  end

  // Extract register fields and the sign-extended immediate for the recognised format
  always_comb begin
    dec_o = '0;
    if (op != OP_NOP) begin
      dec_o.op     = op;
      dec_o.is_mem = (op >= OP_LB) && (op <= OP_SW);
      case (fmt)
        FMT_R: begin
          dec_o.rd = inst_i[11:7]; dec_o.rs1 = inst_i[19:15]; dec_o.rs2 = inst_i[24:20];
          dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
        end
        FMT_I: begin
          dec_o.rd = inst_i[11:7]; dec_o.rs1 = inst_i[19:15]; dec_o.uses_rs1 = 1'b1;
          dec_o.imm = {{20{inst_i[31]}}, inst_i[31:20]};
        end
        FMT_SH: begin
          dec_o.rd = inst_i[11:7]; dec_o.rs1 = inst_i[19:15]; dec_o.uses_rs1 = 1'b1;
          dec_o.imm = {27'd0, inst_i[24:20]};
        end
        FMT_S: begin
          dec_o.rs1 = inst_i[19:15]; dec_o.rs2 = inst_i[24:20];
          dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
          dec_o.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        end
        FMT_B: begin
          dec_o.rs1 = inst_i[19:15]; dec_o.rs2 = inst_i[24:20];
          dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
          dec_o.imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        end
        FMT_U: begin
          dec_o.rd = inst_i[11:7]; dec_o.imm = {inst_i[31:12], 12'd0};
        end
        FMT_J: begin
          dec_o.rd = inst_i[11:7];
          dec_o.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dispatcher.sv
// Issue stage: decodes the IQ head, resolves both source operands to (Q,V)
// through regfile / ROB / both CDBs, allocates a ROB id, renames rd and
// registers one issue record per cycle toward the RS or the LSB.
module dispatcher import dispatcher_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                inst_valid_from_iq,
  input  logic [31:0]         inst_from_iq,
  input  logic [DATA_W-1:0]   pc_from_iq,
  output logic                ack_to_iq,
  input  logic                rob_full,
  input  logic [ROB_ID_W-1:0] rob_free_id,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic [4:0]          rs1_to_reg,
  output logic [4:0]          rs2_to_reg,
  input  logic [ROB_ID_W-1:0] Q1_from_reg,
  input  logic [ROB_ID_W-1:0] Q2_from_reg,
  input  logic [DATA_W-1:0]   V1_from_reg,
  input  logic [DATA_W-1:0]   V2_from_reg,
  output logic [ROB_ID_W-1:0] Q1_to_rob,
  output logic [ROB_ID_W-1:0] Q2_to_rob,
  input  logic                ready1_from_rob,
  input  logic                ready2_from_rob,
  input  logic [DATA_W-1:0]   value1_from_rob,
  input  logic [DATA_W-1:0]   value2_from_rob,
  input  logic                cdb_a_valid,
  input  logic [ROB_ID_W-1:0] cdb_a_rob_id,
  input  logic [DATA_W-1:0]   cdb_a_value,
  input  logic                cdb_l_valid,
  input  logic [ROB_ID_W-1:0] cdb_l_rob_id,
  input  logic [DATA_W-1:0]   cdb_l_value,
  input  logic                rollback,
  output logic                enable_to_rs,
  output logic                enable_to_lsb,
  output logic                enable_to_rob,
  output logic [OPENUM_W-1:0] openum_out,
  output logic [ROB_ID_W-1:0] Q1_out,
  output logic [ROB_ID_W-1:0] Q2_out,
  output logic [ROB_ID_W-1:0] rob_id_out,
  output logic [DATA_W-1:0]   V1_out,
  output logic [DATA_W-1:0]   V2_out,
  output logic [DATA_W-1:0]   imm_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic [4:0]          rd_to_rob,
  output logic                rename_enable_to_reg,
  output logic [4:0]          rename_rd_to_reg,
  output logic [ROB_ID_W-1:0] rename_rob_id_to_reg
);

  typedef struct packed {
    logic [ROB_ID_W-1:0] q;
    logic [DATA_W-1:0]   v;
  } opnd_t;

  // Priority: x0 / unused, regfile value, ROB value, arith CDB, load CDB, else wait on tag.
  function automatic opnd_t resolve(
    input logic                used,
    input logic [4:0]          rs,
    input logic [ROB_ID_W-1:0] q_reg,
    input logic [DATA_W-1:0]   v_reg,
    input logic                rob_rdy,
    input logic [DATA_W-1:0]   rob_val,
    input logic                a_vld,
    input logic [ROB_ID_W-1:0] a_id,
    input logic [DATA_W-1:0]   a_val,
    input logic                l_vld,
    input logic [ROB_ID_W-1:0] l_id,
    input logic [DATA_W-1:0]   l_val
  );
    opnd_t r;
    r = '0;
    if (!used || rs == 5'd0)         r = '0;
    else if (q_reg == ZERO_ROB)      r.v = v_reg;
    else if (rob_rdy)                r.v = rob_val;
    else if (a_vld && a_id == q_reg) r.v = a_val;
    else if (l_vld && l_id == q_reg) r.v = l_val;
    else                             r.q = q_reg;
    return r;
  endfunction

  dec_t   dec;
  opnd_t  op1, op2;
  issue_t iss_d, iss_q;
  logic   unit_full, fire, dispatch;

  dispatcher_decoder u_decoder (
    .inst_i (inst_from_iq),
    .dec_o  (dec)
  );

  assign unit_full = dec.is_mem ? lsb_full : rs_full;
  assign fire      = rdy & inst_valid_from_iq & ~rob_full & ~rollback & ~unit_full;
  // Illegal encodings are acked (dropped) but never reach RS/LSB/ROB.
  assign dispatch  = fire & (dec.op != OP_NOP);

  assign ack_to_iq            = fire;
  assign rs1_to_reg           = dec.rs1;
  assign rs2_to_reg           = dec.rs2;
  assign Q1_to_rob            = Q1_from_reg;
  assign Q2_to_rob            = Q2_from_reg;
  assign rename_enable_to_reg = dispatch & (dec.rd != 5'd0);
  assign rename_rd_to_reg     = dec.rd;
  assign rename_rob_id_to_reg = rob_free_id;

  assign op1 = resolve(dec.uses_rs1, dec.rs1, Q1_from_reg, V1_from_reg, ready1_from_rob,
                       value1_from_rob, cdb_a_valid, cdb_a_rob_id, cdb_a_value,
                       cdb_l_valid, cdb_l_rob_id, cdb_l_value);
  assign op2 = resolve(dec.uses_rs2, dec.rs2, Q2_from_reg, V2_from_reg, ready2_from_rob,
                       value2_from_rob, cdb_a_valid, cdb_a_rob_id, cdb_a_value,
                       cdb_l_valid, cdb_l_rob_id, cdb_l_value);

  // Next issue record: load on dispatch, otherwise drop strobes to a NOP; hold while !rdy
  always_comb begin
    iss_d = iss_q;
    if (rdy) begin
      if (dispatch) begin
        iss_d.en_rs  = ~dec.is_mem;
        iss_d.en_lsb = dec.is_mem;
        iss_d.en_rob = 1'b1;
        iss_d.op     = dec.op;
        iss_d.q1     = op1.q;
        iss_d.v1     = op1.v;
        iss_d.q2     = op2.q;
        iss_d.v2     = op2.v;
        iss_d.imm    = dec.imm;
        iss_d.pc     = pc_from_iq;
        iss_d.rob_id = rob_free_id;
        iss_d.rd     = dec.rd;
      end else begin
        iss_d.en_rs  = 1'b0;
        iss_d.en_lsb = 1'b0;
        iss_d.en_rob = 1'b0;
        iss_d.op     = OP_NOP;
      end
    end
  end

  // Issue register; reset clears every field, which also encodes a NOP
  always_ff @(posedge clk) begin
    if (rst) iss_q <= '0;
    else     iss_q <= iss_d;
  end

  assign enable_to_rs  = iss_q.en_rs;
  assign enable_to_lsb = iss_q.en_lsb;
  assign enable_to_rob = iss_q.en_rob;
  assign openum_out    = iss_q.op;
  assign Q1_out        = iss_q.q1;
  assign Q2_out        = iss_q.q2;
  assign V1_out        = iss_q.v1;
  assign V2_out        = iss_q.v2;
  assign imm_out       = iss_q.imm;
  assign pc_out        = iss_q.pc;
  assign rob_id_out    = iss_q.rob_id;
  assign rd_to_rob     = iss_q.rd;

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: literal directed cases followed by a
// randomized run compared each cycle against a behavioural reference model.
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, inst_valid_from_iq, rob_full, rs_full, lsb_full, rollback;
  logic [31:0] inst_from_iq, pc_from_iq;
  logic [3:0]  rob_free_id, Q1_from_reg, Q2_from_reg, cdb_a_rob_id, cdb_l_rob_id;
  logic [31:0] V1_from_reg, V2_from_reg, value1_from_rob, value2_from_rob, cdb_a_value, cdb_l_value;
  logic ready1_from_rob, ready2_from_rob, cdb_a_valid, cdb_l_valid;
  logic ack_to_iq, enable_to_rs, enable_to_lsb, enable_to_rob, rename_enable_to_reg;
  logic [4:0] rs1_to_reg, rs2_to_reg, rd_to_rob, rename_rd_to_reg;
  logic [3:0] Q1_to_rob, Q2_to_rob, Q1_out, Q2_out, rob_id_out, rename_rob_id_to_reg;
  logic [5:0] openum_out;
  logic [31:0] V1_out, V2_out, imm_out, pc_out;

  always #5 clk = ~clk;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_valid_from_iq(inst_valid_from_iq), .inst_from_iq(inst_from_iq), .pc_from_iq(pc_from_iq),
    .ack_to_iq(ack_to_iq), .rob_full(rob_full), .rob_free_id(rob_free_id),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .ready1_from_rob(ready1_from_rob), .ready2_from_rob(ready2_from_rob),
    .value1_from_rob(value1_from_rob), .value2_from_rob(value2_from_rob),
    .cdb_a_valid(cdb_a_valid), .cdb_a_rob_id(cdb_a_rob_id), .cdb_a_value(cdb_a_value),
    .cdb_l_valid(cdb_l_valid), .cdb_l_rob_id(cdb_l_rob_id), .cdb_l_value(cdb_l_value),
    .rollback(rollback),
    .enable_to_rs(enable_to_rs), .enable_to_lsb(enable_to_lsb), .enable_to_rob(enable_to_rob),
    .openum_out(openum_out), .Q1_out(Q1_out), .Q2_out(Q2_out), .rob_id_out(rob_id_out),
    .V1_out(V1_out), .V2_out(V2_out), .imm_out(imm_out), .pc_out(pc_out), .rd_to_rob(rd_to_rob),
    .rename_enable_to_reg(rename_enable_to_reg), .rename_rd_to_reg(rename_rd_to_reg),
    .rename_rob_id_to_reg(rename_rob_id_to_reg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Generated instruction plus the fields it was built from.
  typedef struct {
    logic [31:0] inst;
    openum_e     op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        u1, u2, mem;
  } gen_t;

  // Expected registered outputs.
  typedef struct {
    logic       en_rs, en_lsb, en_rob;
    openum_e    op;
    logic [3:0] q1, q2, rob;
    logic [31:0] v1, v2, imm, pc;
    logic [4:0] rd;
  } mdl_t;

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  // Encode a random instruction from chosen fields; the expected decode is known by construction.
  function automatic gen_t gen();
    gen_t g;
    logic [11:0] i12; logic [12:0] b13; logic [20:0] j21; logic [19:0] u20; logic [4:0] sh;
    logic [2:0] f3; logic [6:0] f7; int k;
    g.rd = rnd_reg(); g.rs1 = rnd_reg(); g.rs2 = rnd_reg();
    i12 = 12'($urandom); b13 = 13'($urandom) & 13'h1FFE; j21 = 21'($urandom) & 21'h1FFFFE;
    u20 = 20'($urandom); sh = 5'($urandom);
    g.u1 = 0; g.u2 = 0; g.mem = 0; g.imm = 0; g.op = OP_NOP; g.inst = 0;
    case ($urandom_range(0, 11))
      0: begin g.inst = {u20, g.rd, 7'h37}; g.op = OP_LUI;   g.imm = {u20, 12'h0}; end
      1: begin g.inst = {u20, g.rd, 7'h17}; g.op = OP_AUIPC; g.imm = {u20, 12'h0}; end
      2: begin
        g.inst = {j21[20], j21[10:1], j21[11], j21[19:12], g.rd, 7'h6F};
        g.op = OP_JAL; g.imm = {{11{j21[20]}}, j21};
      end
      3: begin
        g.inst = {i12, g.rs1, 3'd0, g.rd, 7'h67}; g.op = OP_JALR; g.u1 = 1;
        g.imm = {{20{i12[11]}}, i12};
      end
      4: begin
        k = $urandom_range(0, 5);
        f3 = (k < 2) ? 3'(k) : 3'(k + 2);
        g.inst = {b13[12], b13[10:5], g.rs2, g.rs1, f3, b13[4:1], b13[11], 7'h63};
        g.op = openum_e'(int'(OP_BEQ) + k); g.rd = 0; g.u1 = 1; g.u2 = 1;
        g.imm = {{19{b13[12]}}, b13};
      end
      5: begin
        k = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        g.inst = {i12, g.rs1, f3, g.rd, 7'h03};
        g.op = openum_e'(int'(OP_LB) + k); g.u1 = 1; g.mem = 1; g.imm = {{20{i12[11]}}, i12};
      end
      6: begin
        k = $urandom_range(0, 2);
        g.inst = {i12[11:5], g.rs2, g.rs1, 3'(k), i12[4:0], 7'h23};
        g.op = openum_e'(int'(OP_SB) + k); g.rd = 0; g.u1 = 1; g.u2 = 1; g.mem = 1;
        g.imm = {{20{i12[11]}}, i12};
      end
      7: begin
        k = $urandom_range(0, 5);
        case (k) 0: f3 = 0; 1: f3 = 2; 2: f3 = 3; 3: f3 = 4; 4: f3 = 6; default: f3 = 7; endcase
        g.inst = {i12, g.rs1, f3, g.rd, 7'h13};
        g.op = openum_e'(int'(OP_ADDI) + k); g.u1 = 1; g.imm = {{20{i12[11]}}, i12};
      end
      8: begin
        k = $urandom_range(0, 2);
        f7 = (k == 2) ? 7'h20 : 7'h00; f3 = (k == 0) ? 3'd1 : 3'd5;
        g.inst = {f7, sh, g.rs1, f3, g.rd, 7'h13};
        g.op = openum_e'(int'(OP_SLLI) + k); g.u1 = 1; g.imm = {27'd0, sh};
      end
      9, 10: begin
        k = $urandom_range(0, 9);
        case (k) 0, 1: f3 = 0; 2: f3 = 1; 3: f3 = 2; 4: f3 = 3; 5: f3 = 4;
                 6, 7: f3 = 5; 8: f3 = 6; default: f3 = 7; endcase
        f7 = (k == 1 || k == 7) ? 7'h20 : 7'h00;
        g.inst = {f7, g.rs2, g.rs1, f3, g.rd, 7'h33};
        g.op = openum_e'(int'(OP_ADD) + k); g.u1 = 1; g.u2 = 1;
      end
      default: begin
        if ($urandom_range(0, 1) == 0) g.inst = {25'($urandom), 7'h7F};
        else                           g.inst = {i12, g.rs1, 3'd3, g.rd, 7'h03};
        g.op = OP_NOP;
      end
    endcase
    return g;
  endfunction

  // Reference operand resolution: returns {Q, V}.
  function automatic logic [35:0] res(input logic used, input logic [4:0] rs, input logic [3:0] q,
                                      input logic [31:0] v, input logic rr, input logic [31:0] rv);
    if (!used || rs == 0) return {4'd0, 32'd0};
    if (q == 0) return {4'd0, v};
    if (rr) return {4'd0, rv};
    if (cdb_a_valid && cdb_a_rob_id == q) return {4'd0, cdb_a_value};
    if (cdb_l_valid && cdb_l_rob_id == q) return {4'd0, cdb_l_value};
    return {q, 32'd0};
  endfunction

  task automatic set_idle();
    rdy = 1; inst_valid_from_iq = 0; inst_from_iq = 0; pc_from_iq = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rollback = 0; rob_free_id = 4'd7;
    Q1_from_reg = 0; Q2_from_reg = 0; V1_from_reg = 0; V2_from_reg = 0;
    ready1_from_rob = 0; ready2_from_rob = 0; value1_from_rob = 0; value2_from_rob = 0;
    cdb_a_valid = 0; cdb_a_rob_id = 0; cdb_a_value = 0;
    cdb_l_valid = 0; cdb_l_rob_id = 0; cdb_l_value = 0;
  endtask

  task automatic post_edge();
    @(posedge clk); #1;
  endtask

  mdl_t mdl;
  gen_t g;
  logic fire, disp;
  logic [35:0] r1, r2;

  initial begin
    set_idle(); rst = 1;
    repeat (2) @(posedge clk); #1;
    chk("rst_en_rs", enable_to_rs, 0);   chk("rst_en_lsb", enable_to_lsb, 0);
    chk("rst_en_rob", enable_to_rob, 0); chk("rst_openum", openum_out, 0);
    chk("rst_q1", Q1_out, 0); chk("rst_v1", V1_out, 0); chk("rst_imm", imm_out, 0);
    chk("rst_pc", pc_out, 0); chk("rst_rob_id", rob_id_out, 0); chk("rst_rd", rd_to_rob, 0);

    // ADDI x1,x0,5 @ pc 0
    @(negedge clk); rst = 0; inst_valid_from_iq = 1; inst_from_iq = 32'h00500093; #1;
    chk("addi_ack", ack_to_iq, 1); chk("addi_ren", rename_enable_to_reg, 1);
    chk("addi_ren_rd", rename_rd_to_reg, 1); chk("addi_ren_id", rename_rob_id_to_reg, 7);
    post_edge();
    chk("addi_en_rs", enable_to_rs, 1); chk("addi_en_lsb", enable_to_lsb, 0);
    chk("addi_en_rob", enable_to_rob, 1); chk("addi_op", openum_out, OP_ADDI);
    chk("addi_q1", Q1_out, 0); chk("addi_v1", V1_out, 0); chk("addi_q2", Q2_out, 0);
    chk("addi_imm", imm_out, 5); chk("addi_rob", rob_id_out, 7); chk("addi_rd", rd_to_rob, 1);

    // ADD x3,x1,x2 with Q1=3 captured from the arith CDB
    @(negedge clk); inst_from_iq = 32'h002081B3; pc_from_iq = 32'h4; Q1_from_reg = 3;
    V2_from_reg = 32'h22; cdb_a_valid = 1; cdb_a_rob_id = 3; cdb_a_value = 32'h10;
    post_edge();
    chk("cdba_q1", Q1_out, 0); chk("cdba_v1", V1_out, 32'h10); chk("cdba_v2", V2_out, 32'h22);
    chk("cdba_op", openum_out, OP_ADD); chk("cdba_pc", pc_out, 32'h4);
    @(negedge clk); cdb_l_valid = 1; cdb_l_rob_id = 3; cdb_l_value = 32'h20;
    post_edge(); chk("cdb_prio_v1", V1_out, 32'h10);
    @(negedge clk); ready1_from_rob = 1; value1_from_rob = 32'h30;
    post_edge(); chk("rob_prio_v1", V1_out, 32'h30);
    @(negedge clk); ready1_from_rob = 0; cdb_a_valid = 0; cdb_l_valid = 0;
    post_edge(); chk("wait_q1", Q1_out, 3); chk("wait_v1", V1_out, 0);

    // LW x5,8(x1) blocked by lsb_full for three cycles
    @(negedge clk); Q1_from_reg = 0; V1_from_reg = 32'h100; inst_from_iq = 32'h0080A283; lsb_full = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1; chk("lw_stall_ack", ack_to_iq, 0);
      post_edge(); chk("lw_stall_lsb", enable_to_lsb, 0); chk("lw_stall_rob", enable_to_rob, 0);
      chk("lw_stall_op", openum_out, OP_NOP);
    end
    @(negedge clk); lsb_full = 0; #1; chk("lw_ack", ack_to_iq, 1);
    post_edge(); chk("lw_en_lsb", enable_to_lsb, 1); chk("lw_en_rs", enable_to_rs, 0);
    chk("lw_imm", imm_out, 8); chk("lw_op", openum_out, OP_LW); chk("lw_v1", V1_out, 32'h100);

    // rob_full, then rollback
    @(negedge clk); inst_from_iq = 32'h002081B3; rob_full = 1; #1;
    chk("robfull_ack", ack_to_iq, 0); chk("robfull_ren", rename_enable_to_reg, 0);
    post_edge(); chk("robfull_rob", enable_to_rob, 0);
    @(negedge clk); rob_full = 0; rollback = 1; #1; chk("rb_ack", ack_to_iq, 0);
    post_edge(); chk("rb_op", openum_out, OP_NOP); chk("rb_en_rs", enable_to_rs, 0);
    @(negedge clk); rollback = 0;
    post_edge(); chk("resume_en_rs", enable_to_rs, 1);
    @(negedge clk); rst = 1;
    post_edge(); chk("midrst_en_rs", enable_to_rs, 0); chk("midrst_op", openum_out, 0);
    chk("midrst_v2", V2_out, 0);

    // ADDI x0,x0,1: dispatched, no rename; then rdy low holds state
    @(negedge clk); rst = 0; inst_from_iq = 32'h00100013; #1;
    chk("x0_ack", ack_to_iq, 1); chk("x0_ren", rename_enable_to_reg, 0);
    post_edge(); chk("x0_en_rs", enable_to_rs, 1);
    @(negedge clk); rdy = 0; inst_from_iq = 32'h002081B3; #1;
    chk("rdy_ack", ack_to_iq, 0); chk("rdy_ren", rename_enable_to_reg, 0);
    post_edge(); chk("rdy_hold_en", enable_to_rs, 1); chk("rdy_hold_op", openum_out, OP_ADDI);
    chk("rdy_hold_imm", imm_out, 1);

    // Randomized run against the reference model
    mdl = '{en_rs: 0, en_lsb: 0, en_rob: 0, op: OP_NOP, q1: 0, q2: 0, rob: 0,
            v1: 0, v2: 0, imm: 0, pc: 0, rd: 0};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gen();
      rst                = (c == 0) || ($urandom_range(0, 99) < 2);
      rdy                = $urandom_range(0, 99) < 88;
      inst_valid_from_iq = $urandom_range(0, 99) < 80;
      rob_full           = $urandom_range(0, 99) < 12;
      rs_full            = $urandom_range(0, 99) < 12;
      lsb_full           = $urandom_range(0, 99) < 12;
      rollback           = $urandom_range(0, 99) < 6;
      inst_from_iq = g.inst; pc_from_iq = $urandom; rob_free_id = 4'($urandom_range(1, 15));
      Q1_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      Q2_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      V1_from_reg = $urandom; V2_from_reg = $urandom;
      ready1_from_rob = $urandom_range(0, 3) == 0; ready2_from_rob = $urandom_range(0, 3) == 0;
      value1_from_rob = $urandom; value2_from_rob = $urandom;
      cdb_a_valid = $urandom_range(0, 1) == 1; cdb_l_valid = $urandom_range(0, 1) == 1;
      cdb_a_rob_id = ($urandom_range(0, 1) == 0) ? Q1_from_reg : Q2_from_reg;
      cdb_l_rob_id = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? Q1_from_reg : Q2_from_reg);
      cdb_a_value = $urandom; cdb_l_value = $urandom;
      #1;
      fire = rdy && inst_valid_from_iq && !rob_full && !rollback && !(g.mem ? lsb_full : rs_full);
      disp = fire && (g.op != OP_NOP);
      chk("r_ack", ack_to_iq, fire);
      chk("r_ren", rename_enable_to_reg, disp && g.rd != 0);
      if (disp && g.rd != 0) begin
        chk("r_ren_rd", rename_rd_to_reg, g.rd); chk("r_ren_id", rename_rob_id_to_reg, rob_free_id);
      end
      if (g.u1) chk("r_rs1", rs1_to_reg, g.rs1);
      if (g.u2) chk("r_rs2", rs2_to_reg, g.rs2);
      chk("r_q1rob", Q1_to_rob, Q1_from_reg);
      r1 = res(g.u1, g.rs1, Q1_from_reg, V1_from_reg, ready1_from_rob, value1_from_rob);
      r2 = res(g.u2, g.rs2, Q2_from_reg, V2_from_reg, ready2_from_rob, value2_from_rob);
      if (rst) begin
        mdl = '{en_rs: 0, en_lsb: 0, en_rob: 0, op: OP_NOP, q1: 0, q2: 0, rob: 0,
                v1: 0, v2: 0, imm: 0, pc: 0, rd: 0};
      end else if (rdy) begin
        if (disp) begin
          mdl = '{en_rs: !g.mem, en_lsb: g.mem, en_rob: 1, op: g.op, q1: r1[35:32], q2: r2[35:32],
                  rob: rob_free_id, v1: r1[31:0], v2: r2[31:0], imm: g.imm, pc: pc_from_iq, rd: g.rd};
        end else begin
          mdl.en_rs = 0; mdl.en_lsb = 0; mdl.en_rob = 0; mdl.op = OP_NOP;
        end
      end
      post_edge();
      chk("r_en_rs", enable_to_rs, mdl.en_rs); chk("r_en_lsb", enable_to_lsb, mdl.en_lsb);
      chk("r_en_rob", enable_to_rob, mdl.en_rob); chk("r_op", openum_out, mdl.op);
      chk("r_q1", Q1_out, mdl.q1); chk("r_q2", Q2_out, mdl.q2);
      chk("r_v1", V1_out, mdl.v1); chk("r_v2", V2_out, mdl.v2);
      chk("r_imm", imm_out, mdl.imm); chk("r_pc", pc_out, mdl.pc);
      chk("r_rob", rob_id_out, mdl.rob); chk("r_rd", rd_to_rob, mdl.rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
